add_round_key_pipe: RTL and testbench
=====================================

ADD_ROUND_KEY_PIPE -- requirements
Module: add_round_key_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter DATA_W, default 128, SHALL set the state/key width in bits and SHALL be a multiple of 8.
REQ-003 Parameter NUM_KEYS, default 11, SHALL set the number of stored round keys (2..16).
REQ-004 Parameter CAESAR_SHIFT, default 3, SHALL set the per-byte additive shift (0..255) used only when the configuration macro is defined.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 key_we  input  1  write strobe for the round-key store.
REQ-008 key_addr  input  4  round-key store index.
REQ-009 key_in  input  DATA_W  round key written when key_we=1.
REQ-010 in_valid  input  1  data_in/round_in valid.
REQ-011 in_ready  output  1  block can accept data this cycle.
REQ-012 data_in  input  DATA_W  state block to be keyed.
REQ-013 round_in  input  4  index of the round key applied to data_in.
REQ-014 out_valid  output  1  data_out/err_out valid.
REQ-015 out_ready  input  1  downstream accepts data_out.
REQ-016 data_out  output  DATA_W  keyed state block.
REQ-017 err_out  output  1  round_in was out of range for the block in data_out.
REQ-018 blk_cnt  output  16  count of blocks accepted on the input, wrapping.

Function
REQ-019 The key store SHALL write key_in to entry key_addr on a clock edge with key_we=1 and key_addr<NUM_KEYS; writes with key_addr>=NUM_KEYS SHALL be ignored.
REQ-020 An input transfer SHALL occur on a clock edge with in_valid=1 and in_ready=1; an output transfer on a clock edge with out_valid=1 and out_ready=1.
REQ-021 in_ready SHALL equal (!out_valid || out_ready), combinationally; there SHALL be a single output register stage.
REQ-022 On an input transfer, data_out SHALL register data_in XOR key[round_in] and out_valid SHALL be 1 on the next cycle (latency 1 cycle).
REQ-023 If key_we=1 and key_addr==round_in in the same cycle as an input transfer, key_in (the new key) SHALL be used (write-through bypass).
REQ-024 If round_in>=NUM_KEYS, data_out SHALL register data_in unmodified and err_out SHALL register 1; otherwise err_out SHALL register 0.
REQ-025 out_valid, data_out and err_out SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 When an output transfer occurs with no input transfer, out_valid SHALL clear on the next cycle; simultaneous input and output transfers SHALL keep out_valid=1 with the new block (full throughput, one block per cycle).
REQ-027 blk_cnt SHALL increment by 1 on each input transfer and wrap from 16'hFFFF to 0.

Reset
REQ-028 While rst_n=0: out_valid=0, data_out=0, err_out=0, blk_cnt=0, all key store entries=0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard any block held in the output register; no output transfer of it SHALL occur.
REQ-030 in_ready SHALL be 1 during and immediately after reset.

Configuration
REQ-031 Macro ARK_CAESAR_EN defined: each byte of the XOR result SHALL have CAESAR_SHIFT added modulo 256 before registration, including for err_out=1 blocks (data_in bytes shifted).
REQ-032 Macro ARK_CAESAR_EN undefined: no shift logic SHALL exist; data_out per REQ-022/REQ-024 exactly; CAESAR_SHIFT unused.

Verification
REQ-033 Write key[0]=000102..0F, send data_in=00112233445566778899AABBCCDDEEFF round_in=0 -> next cycle out_valid=1, data_out=00102030405060708090A0B0C0D0E0F0, err_out=0.
REQ-034 Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, data_out stable, blk_cnt unchanged; release -> one block per cycle, blk_cnt +1 per cycle.
REQ-035 Same-cycle key_we=1 key_addr=3 key_in=all-FF with data_in=0 round_in=3 -> data_out=all-FF.
REQ-036 round_in=11 (NUM_KEYS=11) data_in=A5 repeated -> data_out=A5 repeated, err_out=1; key_addr=12 write -> store unchanged.
REQ-037 ARK_CAESAR_EN, CAESAR_SHIFT=3, key=0, data_in bytes FE -> data_out bytes 01 (wrap); assert rst_n=0 with out_valid=1 -> out_valid=0, blk_cnt=0 immediately.

Source files
------------

// File: rtl/add_round_key_pipe.sv
// add_round_key_pipe: round-key store plus one-stage XOR pipeline with valid/ready handshake.
// Optional macro ARK_CAESAR_EN adds CAESAR_SHIFT to every result byte.
`default_nettype none

module add_round_key_pipe #(
  parameter int DATA_W       = 128,
  parameter int NUM_KEYS     = 11,
  parameter int CAESAR_SHIFT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_we,
  input  logic [3:0]        key_addr,
  input  logic [DATA_W-1:0] key_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [3:0]        round_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              err_out,
  output logic [15:0]       blk_cnt
);

  localparam int NUM_BYTES = DATA_W / 8;

  logic [DATA_W-1:0] key_mem [NUM_KEYS];
  logic [DATA_W-1:0] key_sel;
  logic [DATA_W-1:0] xor_res;
  logic [DATA_W-1:0] next_data;
  logic              round_ok;
  logic              in_fire;

  // One register per entry; addresses at or beyond NUM_KEYS match no entry.
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        key_mem[k] <= '0;
      end else if (key_we && (key_addr == 4'(k))) begin
        key_mem[k] <= key_in;
      end
    end
  end

  assign round_ok = ({1'b0, round_in} < 5'(NUM_KEYS));

  // A same-cycle write to the selected entry takes precedence over the stored key.
  always_comb begin
    key_sel = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (round_in == 4'(k)) key_sel = key_mem[k];
    end
    if (key_we && (key_addr == round_in)) key_sel = key_in;
  end

  assign xor_res = round_ok ? (data_in ^ key_sel) : data_in;

`ifdef ARK_CAESAR_EN
  for (genvar b = 0; b < NUM_BYTES; b++) begin : g_caesar
    assign next_data[b*8 +: 8] = xor_res[b*8 +: 8] + 8'(CAESAR_SHIFT);
  end
`else
  assign next_data = xor_res;
`endif

  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      err_out   <= 1'b0;
      blk_cnt   <= '0;
    end else begin
      if (in_fire) begin
        out_valid <= 1'b1;
        data_out  <= next_data;
        err_out   <= !round_ok;
        blk_cnt   <= blk_cnt + 16'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_add_round_key_pipe.sv
// tb_add_round_key_pipe: directed self-checking bench for add_round_key_pipe (default parameters).
`default_nettype none

module tb_add_round_key_pipe;

  localparam int W = 128;
  localparam logic [W-1:0] KEY0 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [W-1:0] PAT  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] A5S  = {16{8'hA5}};
  localparam logic [W-1:0] FES  = {16{8'hFE}};

  logic          clk = 1'b0;
  logic          rst_n, key_we, in_valid, out_ready;
  logic          in_ready, out_valid, err_out;
  logic [3:0]    key_addr, round_in;
  logic [W-1:0]  key_in, data_in, data_out;
  logic [15:0]   blk_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  add_round_key_pipe dut (
    .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_addr(key_addr), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in), .round_in(round_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .err_out(err_out), .blk_cnt(blk_cnt)
  );

  // Expected post-processing of a keyed block when the byte shift is built in.
  function automatic logic [W-1:0] cz(input logic [W-1:0] x);
    logic [W-1:0] r;
    r = x;
`ifdef ARK_CAESAR_EN
    for (int i = 0; i < W/8; i++) r[i*8 +: 8] = x[i*8 +: 8] + 8'd3;
`endif
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input logic [3:0] a, input logic [W-1:0] v);
    key_we = 1'b1; key_addr = a; key_in = v;
    step();
    key_we = 1'b0;
  endtask

  task automatic send(input logic [3:0] r, input logic [W-1:0] d);
    in_valid = 1'b1; round_in = r; data_in = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_we = 1'b0; key_addr = '0; key_in = '0;
    in_valid = 1'b0; data_in = '0; round_in = '0; out_ready = 1'b1;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL rst_data_out: got %h want 0", data_out); end
    checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL rst_err_out: got %b want 0", err_out); end
    checks++; if (blk_cnt !== 16'd0) begin errors++; $display("FAIL rst_blk_cnt: got %0d want 0", blk_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    write_key(4'd0, KEY0);
    send(4'd0, 128'h00112233445566778899AABBCCDDEEFF);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    checks++; if (data_out !== cz(128'h00102030405060708090A0B0C0D0E0F0)) begin errors++; $display("FAIL basic_data: got %h want %h", data_out, cz(128'h00102030405060708090A0B0C0D0E0F0)); end
    checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err_out); end
    checks++; if (blk_cnt !== 16'd1) begin errors++; $display("FAIL basic_cnt: got %0d want 1", blk_cnt); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(4'd0, '0);
    step();
    send(4'd0, ONES);
    for (int i = 0; i < 5; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || data_out !== cz(KEY0)) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 %h", i, out_valid, data_out, cz(KEY0)); end
      checks++; if (blk_cnt !== 16'd2) begin errors++; $display("FAIL bp_cnt[%0d]: got %0d want 2", i, blk_cnt); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    step();
    checks++; if (data_out !== cz(ONES ^ KEY0) || blk_cnt !== 16'd3) begin errors++; $display("FAIL bp_stream1: got %h cnt=%0d want %h cnt=3", data_out, blk_cnt, cz(ONES ^ KEY0)); end
    send(4'd0, 128'h1);
    step();
    checks++; if (data_out !== cz(128'h000102030405060708090A0B0C0D0E0E) || blk_cnt !== 16'd4) begin errors++; $display("FAIL bp_stream2: got %h cnt=%0d want %h cnt=4", data_out, blk_cnt, cz(128'h000102030405060708090A0B0C0D0E0E)); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_bypass();
    key_we = 1'b1; key_addr = 4'd3; key_in = ONES;
    send(4'd3, '0);
    step();
    key_we = 1'b0;
    checks++; if (data_out !== cz(ONES) || err_out !== 1'b0) begin errors++; $display("FAIL bypass_data: got %h err=%b want %h err=0", data_out, err_out, cz(ONES)); end
    step();
    in_valid = 1'b0;
    checks++; if (data_out !== cz(ONES)) begin errors++; $display("FAIL bypass_stored: got %h want %h", data_out, cz(ONES)); end
  endtask

  task automatic test_range();
    write_key(4'd10, PAT);
    write_key(4'd11, ONES);
    write_key(4'd12, ONES);
    send(4'd11, A5S);
    step();
    checks++; if (data_out !== cz(A5S) || err_out !== 1'b1) begin errors++; $display("FAIL range_r11: got %h err=%b want %h err=1", data_out, err_out, cz(A5S)); end
    send(4'd10, '0);
    step();
    checks++; if (data_out !== cz(PAT) || err_out !== 1'b0) begin errors++; $display("FAIL range_r10: got %h err=%b want %h err=0", data_out, err_out, cz(PAT)); end
    send(4'd0, '0);
    step();
    checks++; if (data_out !== cz(KEY0) || err_out !== 1'b0) begin errors++; $display("FAIL range_key0_intact: got %h err=%b want %h err=0", data_out, err_out, cz(KEY0)); end
    send(4'd12, '0);
    step();
    in_valid = 1'b0;
    checks++; if (data_out !== cz('0) || err_out !== 1'b1) begin errors++; $display("FAIL range_r12: got %h err=%b want %h err=1", data_out, err_out, cz('0)); end
    step();
    checks++; if (blk_cnt !== 16'd10) begin errors++; $display("FAIL range_cnt: got %0d want 10", blk_cnt); end
  endtask

  task automatic test_shift_and_async_reset();
    out_ready = 1'b0;
    send(4'd4, FES);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || data_out !== cz(FES)) begin errors++; $display("FAIL shift_data: got v=%b %h want v=1 %h", out_valid, data_out, cz(FES)); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || data_out !== '0 || err_out !== 1'b0) begin errors++; $display("FAIL midrst_out: got v=%b %h err=%b want v=0 0 err=0", out_valid, data_out, err_out); end
    checks++; if (blk_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt: got %0d want 0", blk_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(4'd0, '0);
    step();
    in_valid = 1'b0;
    checks++; if (data_out !== cz('0) || blk_cnt !== 16'd1) begin errors++; $display("FAIL midrst_key_cleared: got %h cnt=%0d want %h cnt=1", data_out, blk_cnt, cz('0)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bypass();
    test_range();
    test_shift_and_async_reset();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
